// File: rtl/id_stage_if.sv
// ID/EX bundle presented by the decode stage to EX.
// master = id_stage (drives), slave = EX stage (consumes).
interface id_stage_if;
  logic        ex_valid;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dst;
  logic [2:0]  ex_alu_op;
  logic        ex_alu_src;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_illegal;

  modport master (
    output ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dst,
           ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_illegal
  );
  modport slave (
    input  ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dst,
           ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_illegal
  );
endinterface

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, register file, decoder, load-use stall, ID/EX register.
// Optional macro ID_RF_BYPASS_EN: write-first forwarding of wb_data onto the RF read ports.
module id_stage #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_instr,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        PC_write,
  id_stage_if.master  ex
);
  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        illegal;
  } idex_t;

  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;
  logic [31:0] r_rf [NREG];
  idex_t       r_idex;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_rs_data, w_rt_data;
  logic        w_legal, w_reads_rt, w_stall;
  idex_t       w_dec, w_idex_nxt;

  assign w_op    = r_ifid_instr[31:26];
  assign w_rs    = r_ifid_instr[25:21];
  assign w_rt    = r_ifid_instr[20:16];
  assign w_rd    = r_ifid_instr[15:11];
  assign w_funct = r_ifid_instr[5:0];

  always_comb begin
    w_rs_data = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
    w_rt_data = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
`ifdef ID_RF_BYPASS_EN
    if (wb_we && wb_addr != 5'd0 && wb_addr == w_rs) w_rs_data = wb_data;
    if (wb_we && wb_addr != 5'd0 && wb_addr == w_rt) w_rt_data = wb_data;
`endif
  end

  always_comb begin
    w_dec         = '0;
    w_legal       = 1'b0;
    w_reads_rt    = 1'b0;
    w_dec.valid   = 1'b1;
    w_dec.rs      = w_rs;
    w_dec.rt      = w_rt;
    w_dec.rs_data = w_rs_data;
    w_dec.rt_data = w_rt_data;
    w_dec.imm     = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
    case (w_op)
      6'b000000: begin
        w_reads_rt      = 1'b1;
        w_dec.dst       = w_rd;
        w_dec.reg_write = 1'b1;
        w_legal         = 1'b1;
        case (w_funct)
          6'd0:    w_dec.alu_op = 3'b000;
          6'd2:    w_dec.alu_op = 3'b001;
          6'd4:    w_dec.alu_op = 3'b010;
          6'd5:    w_dec.alu_op = 3'b011;
          6'd6:    w_dec.alu_op = 3'b100;
          default: w_legal      = 1'b0;
        endcase
      end
      6'b000010, 6'b000011: begin
        w_dec.alu_src   = 1'b1;
        w_dec.dst       = w_rt;
        w_dec.reg_write = 1'b1;
        w_dec.mem_read  = w_op[0];
        w_legal         = 1'b1;
      end
      6'b000001: begin
        w_reads_rt      = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
        w_legal         = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    if (w_dec.dst == 5'd0) w_dec.reg_write = 1'b0;
  end

  // Load in EX whose result a consumer in ID needs: hold ID one cycle.
  assign w_stall = r_idex.valid & r_idex.mem_read & (r_idex.dst != 5'd0) &
                   ((r_idex.dst == w_rs) | ((r_idex.dst == w_rt) & w_reads_rt));
  assign PC_write = ~w_stall;

  always_comb begin
    w_idex_nxt = '0;
    if (!w_stall && r_ifid_valid) begin
      if (w_legal) w_idex_nxt = w_dec;
      else         w_idex_nxt.illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
      r_idex       <= '0;
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      if (PC_write) begin
        r_ifid_instr <= if_instr;
        r_ifid_valid <= 1'b1;
      end
      r_idex <= w_idex_nxt;
      if (wb_we && wb_addr != 5'd0) r_rf[wb_addr] <= wb_data;
    end
  end

  assign ex.ex_valid     = r_idex.valid;
  assign ex.ex_rs_data   = r_idex.rs_data;
  assign ex.ex_rt_data   = r_idex.rt_data;
  assign ex.ex_imm       = r_idex.imm;
  assign ex.ex_rs        = r_idex.rs;
  assign ex.ex_rt        = r_idex.rt;
  assign ex.ex_dst       = r_idex.dst;
  assign ex.ex_alu_op    = r_idex.alu_op;
  assign ex.ex_alu_src   = r_idex.alu_src;
  assign ex.ex_mem_read  = r_idex.mem_read;
  assign ex.ex_mem_write = r_idex.mem_write;
  assign ex.ex_reg_write = r_idex.reg_write;
  assign ex.ex_illegal   = r_idex.illegal;
endmodule
